// File: rtl/inv_cipher_ctrl.sv
// inv_cipher_ctrl -- iterative AES inverse cipher, one inverse round per clock.
//
// Decrypts a 128-bit block with round keys from an external key store. The
// store is addressed by key_idx_o and returns rk_in_i combinationally in the
// same cycle. The key index walks NR, NR-1, ..., 1, 0 with no gaps:
//   IDLE  : initial AddRoundKey with key NR when a block is accepted
//   ROUND : InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (keys NR-1..1)
//   FINAL : InvShiftRows, InvSubBytes, AddRoundKey (key 0), result to out_data_o
//   DONE  : out_valid_o held until out_ready_i
// Counting the accepting edge as the first, out_valid_o rises on edge NR+1.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid_i   ciphertext offered     in_ready_o   block accepts (IDLE only)
//   in_data_i    ciphertext [0:127]; bit 0 is the MSB of byte 0
//   key_idx_o    round-key index        rk_in_i      round key for key_idx_o
//   out_valid_o  plaintext available    out_ready_i  consumer accepts plaintext
//   out_data_o   plaintext              busy_o       high outside IDLE
//   abort_i      only with INV_CIPHER_ABORT_EN: return to IDLE from any busy state
//
// Parameter NR: number of rounds (10, 12 or 14).
// Optional feature macro: INV_CIPHER_ABORT_EN.

module inv_cipher_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic           clk,
    input  logic           rst_n,
`ifdef INV_CIPHER_ABORT_EN
    input  logic           abort_i,
`endif
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [0:127]   in_data_i,
    output logic [3:0]     key_idx_o,
    input  logic [0:127]   rk_in_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [0:127]   out_data_o,
    output logic           busy_o
);

    localparam logic [3:0] NrIdx = 4'(NR);
    localparam logic [3:0] NrM1  = 4'(NR - 1);

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [0:127]   st_q, st_d;
    logic [0:127]   out_q, out_d;
    logic [0:127]   sub_key;
    logic [0:127]   mixed;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse S-box: inverse affine map, then multiplicative inverse as x^254
    // (which also maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] x;
        logic [7:0] t;
        logic [7:0] p;
        x = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        t = x;
        p = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            p = gf_mul(p, t);
        end
        return p;
    endfunction

    // Byte b of the block is state element (row b%4, column b/4).
    function automatic logic [0:127] inv_shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[8*(4*c+row) +: 8] = s[8*(4*((c - row + 4) % 4) + row) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] inv_sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int b = 0; b < 16; b++) begin
            r[8*b +: 8] = inv_sbox(s[8*b +: 8]);
        end
        return r;
    endfunction

    function automatic logic [0:127] inv_mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            r[8*(4*c)   +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                                gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[8*(4*c+1) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                                gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[8*(4*c+2) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                                gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[8*(4*c+3) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                                gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    // Round datapath shared by ROUND and FINAL; FINAL takes sub_key unmixed.
    always_comb begin
        sub_key = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_in_i;
        mixed   = inv_mix_columns(sub_key);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        out_d       = out_q;
        in_ready_o  = 1'b0;
        key_idx_o   = 4'd0;
        out_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Gated by rst_n so in_ready_o reads 0 while reset is held.
                in_ready_o = rst_n;
                key_idx_o  = NrIdx;
                if (in_valid_i) begin
                    st_d    = in_data_i ^ rk_in_i;
                    cnt_d   = NrM1;
                    state_d = StRound;
                end
            end
            StRound: begin
                key_idx_o = cnt_q;
                st_d      = mixed;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = StFinal;
            end
            StFinal: begin
                key_idx_o = 4'd0;
                out_d     = sub_key;
                state_d   = StDone;
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef INV_CIPHER_ABORT_EN
        // Abort wins over everything outside IDLE; the last plaintext is kept.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            out_d   = out_q;
        end
`endif
    end

    assign busy_o     = (state_q != StIdle);
    assign out_data_o = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            st_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: doc/inv_cipher_ctrl.md
INV_CIPHER_CTRL -- requirements
Module: inv_cipher_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: NR, default 10, number of cipher rounds; legal values are 10, 12 and 14.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  ciphertext block offered.
REQ-006 in_ready  output  1  block accepts ciphertext.
REQ-007 in_data  input  [0:127]  ciphertext; bit 0 is the MSB of byte 0.
REQ-008 key_idx  output  4  round-key index requested from the external key store.
REQ-009 rk_in  input  [0:127]  round key for key_idx, valid combinationally in the same cycle.
REQ-010 out_valid  output  1  plaintext available.
REQ-011 out_ready  input  1  consumer accepts plaintext.
REQ-012 out_data  output  [0:127]  plaintext.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, ROUND, FINAL and DONE.
REQ-015 Per-state outputs SHALL be:
- IDLE: in_ready=1, key_idx=NR.
- ROUND: key_idx=round counter.
- FINAL: key_idx=0.
- DONE: out_valid=1.
- All other states drive these outputs 0.
REQ-016 IDLE with in_valid=1 SHALL:
- load the state register with in_data XOR rk_in (initial AddRoundKey);
- load the round counter with NR-1;
- go to ROUND.
REQ-017 In ROUND the block SHALL process the state through one inverse round per cycle, using the existing round datapath: inv_shift_rows, inv_sub_bytes, AddRoundKey with rk_in, then inv_mixcol.
- The result is registered into the state register.
- The counter decrements each cycle.
- When the counter equals 1, the next state is FINAL.
REQ-018 In FINAL the block SHALL apply inv_shift_rows, inv_sub_bytes and AddRoundKey with rk_in and no inv_mixcol.
- The result is registered into out_data.
- The next state is DONE.
REQ-019 Latency: out_valid SHALL rise exactly NR+1 clock edges after the accepting edge (11 for NR=10).
REQ-020 key_idx SHALL follow this sequence: NR, NR-1, …, 1, 0, one value per cycle, with no gaps.
REQ-021 DONE SHALL hold out_valid and out_data stable until out_ready=1; that cycle is the transfer and the next state is IDLE.
REQ-022 in_valid SHALL be ignored outside IDLE; the block does not overlap two blocks.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 out_data SHALL change only on the FINAL-to-DONE edge.

Reset
REQ-025 While rst_n=0, regardless of clock, the block SHALL force:
- state=IDLE and busy=0;
- in_ready=0 until the first clock edge after deassertion;
- out_valid=0 and out_data=0;
- key_idx=NR, counter=0, state register=0.
REQ-026 Reset asserted mid-operation SHALL discard the block in flight with no output produced.
REQ-027 The first edge after reset release SHALL be able to accept a block.

Configuration
REQ-028 With the macro INV_CIPHER_ABORT_EN defined:
- An input port abort (1 bit) SHALL exist.
- abort=1 in ROUND, FINAL or DONE SHALL return the FSM to IDLE on the next edge.
- The returning edge clears out_valid and busy; out_data is left unchanged.
- abort SHALL be ignored in IDLE.
- abort has priority over out_ready in DONE.
REQ-029 Without INV_CIPHER_ABORT_EN the abort port SHALL be absent and behaviour SHALL be as REQ-014 to REQ-024.

Verification
REQ-030 NR=10; the key store is loaded with the FIPS-197 expansion of key 000102030405060708090a0b0c0d0e0f; in_data=69c4e0d86a7b0430d8cdb78070b4c55a -> out_data=00112233445566778899aabbccddeeff, with out_valid rising 11 edges after acceptance.
REQ-031 Same stimulus, with key_idx sampled every cycle -> the sequence is 10,9,…,1,0 with no repeats.
REQ-032 out_ready held 0 for 20 cycles in DONE -> out_valid stays 1, out_data stable, in_ready stays 0; out_ready=1 -> IDLE next edge.
REQ-033 A second in_valid pulse with different data during ROUND -> ignored; the result equals REQ-030's plaintext.
REQ-034 rst_n asserted in ROUND at counter=5, then released, then the REQ-030 vector applied -> correct plaintext with no spurious out_valid.
REQ-035 With INV_CIPHER_ABORT_EN, abort=1 in ROUND at counter=3 -> IDLE, busy=0, out_valid=0 next edge; the following block decrypts correctly.
